// File: rtl/cpu_run_controller.sv
// Run-control sequencer for CPUTop: holds the CPU in reset for RESET_CYCLES, counts
// RUN cycles and retired instructions, and ends the run on an END_REG write or timeout.
module cpu_run_controller #(
    parameter int          RESET_CYCLES   = 4,
    parameter int          TIMEOUT_CYCLES = 200000,
    parameter int          CNT_W          = 32,
    parameter int          END_REG        = 17,
    parameter logic [31:0] PASS_VALUE     = 32'h0000_0001
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             restart,
    input  logic             rf_we,
    input  logic [4:0]       rf_waddr,
    input  logic [31:0]      rf_wdata,
    input  logic             retire,
    output logic             cpu_nrst,
    output logic             running,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count,
    output logic [31:0]      end_value,
    output logic [1:0]       dbg_state
);

    // Timeout runs off its own counter so a narrow, saturating cycle_count cannot hide it.
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [7:0]       rst_cnt, rst_cnt_d;
    logic [TW-1:0]    run_cnt, run_cnt_d;
    logic [CNT_W-1:0] cyc_d, ret_d;
    logic [31:0]      endv_d;
    logic             pass_d, fail_d, timeout_d;
    logic             end_hit, time_hit;

    always_comb begin
        state_d   = state;
        rst_cnt_d = rst_cnt;
        run_cnt_d = run_cnt;
        cyc_d     = cycle_count;
        ret_d     = retire_count;
        endv_d    = end_value;
        pass_d    = pass;
        fail_d    = fail;
        timeout_d = timeout;
        end_hit   = rf_we && (rf_waddr == 5'(END_REG));
        time_hit  = (run_cnt == TW'(TIMEOUT_CYCLES - 1));
        case (state)
            S_RESET: begin
                rst_cnt_d = rst_cnt + 8'd1;
                run_cnt_d = '0;
                cyc_d     = '0;
                ret_d     = '0;
                if (rst_cnt == 8'(RESET_CYCLES - 1)) state_d = S_RUN;
            end
            S_RUN: begin
                if (retire && (retire_count != CNT_MAX)) ret_d = retire_count + CNT_W'(1);
                // End-of-test beats timeout when both land in the same cycle.
                if (end_hit) begin
                    endv_d  = rf_wdata;
                    pass_d  = (rf_wdata == PASS_VALUE);
                    fail_d  = (rf_wdata != PASS_VALUE);
                    state_d = S_DONE;
                end else if (time_hit) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    run_cnt_d = run_cnt + TW'(1);
                    if (cycle_count != CNT_MAX) cyc_d = cycle_count + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (restart) begin
                    state_d   = S_RESET;
                    rst_cnt_d = '0;
                    run_cnt_d = '0;
                    cyc_d     = '0;
                    ret_d     = '0;
                    endv_d    = '0;
                    pass_d    = 1'b0;
                    fail_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = S_RESET;
        endcase
    end

    // done acts as the result-valid strobe: pass/fail/timeout/counters/end_value are
    // meaningful and stable while done=1; there is no ready, the result simply holds.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state        <= S_RESET;
            rst_cnt      <= '0;
            run_cnt      <= '0;
            cycle_count  <= '0;
            retire_count <= '0;
            end_value    <= '0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            timeout      <= 1'b0;
            cpu_nrst     <= 1'b0;
            running      <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_d;
            rst_cnt      <= rst_cnt_d;
            run_cnt      <= run_cnt_d;
            cycle_count  <= cyc_d;
            retire_count <= ret_d;
            end_value    <= endv_d;
            pass         <= pass_d;
            fail         <= fail_d;
            timeout      <= timeout_d;
            cpu_nrst     <= (state_d == S_RUN);
            running      <= (state_d == S_RUN);
            done         <= (state_d == S_DONE);
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: two instances (wide counters / narrow saturating counters)
// share randomized stimulus; a per-run outcome model feeds scoreboards checked on done.
module tb_cpu_run_controller;

    localparam int RC = 4;
    localparam int TA = 50;
    localparam int WA = 32;
    localparam int TB = 40;
    localparam int WB = 4;
    localparam int DIR10 = -1;

    logic        sysclk = 1'b0;
    logic        rst = 1'b1, restart = 1'b0, rf_we = 1'b0, retire = 1'b0;
    logic [4:0]  rf_waddr = '0;
    logic [31:0] rf_wdata = '0;

    logic a_cpu_nrst, a_running, a_done, a_pass, a_fail, a_timeout;
    logic [WA-1:0] a_cycle_count, a_retire_count;
    logic [31:0] a_end_value;
    logic [1:0]  a_dbg_state;
    logic b_cpu_nrst, b_running, b_done, b_pass, b_fail, b_timeout;
    logic [WB-1:0] b_cycle_count, b_retire_count;
    logic [31:0] b_end_value;
    logic [1:0]  b_dbg_state;

    always #5 sysclk = ~sysclk;

    cpu_run_controller #(.RESET_CYCLES(RC), .TIMEOUT_CYCLES(TA), .CNT_W(WA)) dut_a (
        .sysclk(sysclk), .rst(rst), .restart(restart), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .retire(retire), .cpu_nrst(a_cpu_nrst), .running(a_running),
        .done(a_done), .pass(a_pass), .fail(a_fail), .timeout(a_timeout),
        .cycle_count(a_cycle_count), .retire_count(a_retire_count), .end_value(a_end_value),
        .dbg_state(a_dbg_state));

    cpu_run_controller #(.RESET_CYCLES(RC), .TIMEOUT_CYCLES(TB), .CNT_W(WB)) dut_b (
        .sysclk(sysclk), .rst(rst), .restart(restart), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .retire(retire), .cpu_nrst(b_cpu_nrst), .running(b_running),
        .done(b_done), .pass(b_pass), .fail(b_fail), .timeout(b_timeout),
        .cycle_count(b_cycle_count), .retire_count(b_retire_count), .end_value(b_end_value),
        .dbg_state(b_dbg_state));

    typedef struct packed {
        logic        nrst;
        logic        running;
        logic        pass;
        logic        fail;
        logic        timeout;
        logic [31:0] cyc;
        logic [31:0] ret;
        logic [31:0] endv;
    } res_t;

    res_t exp_a_q[$];
    res_t exp_b_q[$];
    res_t last_a, last_b;
    int   n_chk = 0;
    int   n_pass = 0;
    logic r_plan[64];
    int   ign_addr[64];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic res_t act_a();
        return {a_cpu_nrst, a_running, a_pass, a_fail, a_timeout,
                a_cycle_count, a_retire_count, a_end_value};
    endfunction

    function automatic res_t act_b();
        return {b_cpu_nrst, b_running, b_pass, b_fail, b_timeout,
                28'd0, b_cycle_count, 28'd0, b_retire_count, b_end_value};
    endfunction

    // Outcome of one run from the rules: where it stops, what it counted, how it ended.
    function automatic res_t model(input int t, input int w, input int end_k, input logic [31:0] data);
        res_t   m;
        longint maxv = (longint'(1) << w) - 1;
        bit     ended = (end_k >= 0) && (end_k <= t - 1);
        int     stop = ended ? end_k : t - 1;
        int     sum = 0;
        for (int i = 0; i <= stop; i++) sum += int'(r_plan[i]);
        m.nrst    = 1'b0;
        m.running = 1'b0;
        m.pass    = ended && (data == 32'h1);
        m.fail    = ended && (data != 32'h1);
        m.timeout = !ended;
        m.cyc     = 32'((longint'(stop) < maxv) ? longint'(stop) : maxv);
        m.ret     = 32'((longint'(sum) < maxv) ? longint'(sum) : maxv);
        m.endv    = ended ? data : 32'h0;
        return m;
    endfunction

    // Monitor: one scoreboard pop per rising done on each instance.
    logic prev_a = 1'b0, prev_b = 1'b0;
    always @(negedge sysclk) begin
        if (a_done === 1'b1 && prev_a !== 1'b1) begin
            if (exp_a_q.size() == 0) begin
                n_chk++;
                $display("FAIL a_unexpected_done: got done=1 expected no result pending");
            end else chk("a_result", act_a(), exp_a_q.pop_front());
        end
        if (b_done === 1'b1 && prev_b !== 1'b1) begin
            if (exp_b_q.size() == 0) begin
                n_chk++;
                $display("FAIL b_unexpected_done: got done=1 expected no result pending");
            end else chk("b_result", act_b(), exp_b_q.pop_front());
        end
        prev_a = a_done;
        prev_b = b_done;
    end

    task automatic clear_inputs();
        restart = 1'b0; rf_we = 1'b0; retire = 1'b0; rf_waddr = '0; rf_wdata = '0;
    endtask

    task automatic launch_rst();
        rst = 1'b1;
        @(posedge sysclk);
        @(negedge sysclk);
        chk("rst_zero_a", {a_cpu_nrst, a_running, a_done, a_pass, a_fail, a_timeout,
                           a_cycle_count, a_retire_count, a_end_value}, '0);
        chk("rst_zero_b", {b_cpu_nrst, b_running, b_done, b_pass, b_fail, b_timeout,
                           b_cycle_count, b_retire_count, b_end_value}, '0);
        @(posedge sysclk);
        #1 rst = 1'b0;
    endtask

    task automatic launch_restart();
        @(negedge sysclk);
        restart = 1'b1;
        @(posedge sysclk);
        #1 restart = 1'b0;
    endtask

    task automatic do_run(input int end_k, input logic [31:0] data, input int density,
                          input int restart_c, input int abort_c, input int n_ign);
        int last, c, placed;
        bit ended_a;
        ended_a = (end_k >= 0) && (end_k <= TA - 1);
        last = ended_a ? end_k : TA - 1;
        if (abort_c >= 0) last = abort_c - 1;
        for (int i = 0; i < 64; i++) begin
            r_plan[i]   = (density < 0) ? (i < 10) : ($urandom_range(0, 99) < density);
            ign_addr[i] = -1;
        end
        placed = 0;
        for (int i = 0; i < n_ign; i++) begin
            c = $urandom_range(0, last);
            if (c != end_k && ign_addr[c] < 0) begin
                if (placed == 0) ign_addr[c] = 0;
                else if (placed == 1) ign_addr[c] = 16;
                else begin
                    ign_addr[c] = $urandom_range(0, 31);
                    if (ign_addr[c] == 17) ign_addr[c] = 18;
                end
                placed++;
            end
        end
        if (abort_c < 0) begin
            last_a = model(TA, WA, end_k, data);
            last_b = model(TB, WB, end_k, data);
            exp_a_q.push_back(last_a);
            exp_b_q.push_back(last_b);
        end
        for (int i = 0; i < RC; i++) begin
            @(negedge sysclk);
            chk("nrst_low", {a_cpu_nrst, a_running, b_cpu_nrst, b_running}, '0);
            @(posedge sysclk);
        end
        @(negedge sysclk);
        chk("run_start", {a_cpu_nrst, a_running, a_done, a_cycle_count, a_retire_count,
                          b_cpu_nrst, b_running, b_done, b_cycle_count, b_retire_count},
            {1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0});
        for (int k = 0; k <= last; k++) begin
            retire   = r_plan[k];
            restart  = (k == restart_c);
            if (k == end_k) begin
                rf_we = 1'b1; rf_waddr = 5'd17; rf_wdata = data;
            end else if (ign_addr[k] >= 0) begin
                rf_we = 1'b1; rf_waddr = 5'(ign_addr[k]); rf_wdata = 32'h1;
            end else begin
                rf_we = 1'b0; rf_waddr = 5'($urandom_range(0, 31)); rf_wdata = $urandom;
            end
            @(posedge sysclk);
            @(negedge sysclk);
        end
        clear_inputs();
        if (abort_c >= 0) begin
            chk("abort_point", {a_running, a_cycle_count, b_running, b_cycle_count},
                {1'b1, 32'(abort_c), 1'b1, 4'((abort_c > 15) ? 15 : abort_c)});
        end else begin
            for (int k = 0; k < 3; k++) begin
                rf_we = 1'b1; rf_waddr = 5'd17; rf_wdata = $urandom; retire = 1'b1;
                @(posedge sysclk);
                @(negedge sysclk);
            end
            clear_inputs();
            chk("a_frozen", {a_done, act_a()}, {1'b1, last_a});
            chk("b_frozen", {b_done, act_b()}, {1'b1, last_b});
            chk("results_drained", 128'(exp_a_q.size() + exp_b_q.size()), 128'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int ek, eff, rc;
        logic [31:0] dv;
        launch_rst();
        do_run(25, 32'h1, DIR10, -1, -1, 0);
        launch_restart();
        do_run(20, 32'hDEAD_BEEF, 50, -1, -1, 4);
        launch_restart();
        do_run(-1, 32'h1, 100, -1, -1, 0);
        launch_restart();
        do_run(49, 32'h1, 30, -1, -1, 0);
        launch_restart();
        do_run(35, 32'h1, 40, 10, -1, 1);
        launch_restart();
        do_run(-1, 32'h1, 50, -1, 30, 0);
        launch_rst();
        do_run(12, 32'h1, 60, 5, -1, 2);
        for (int n = 0; n < 12; n++) begin
            ek = ($urandom_range(0, 9) < 2) ? -1 : int'($urandom_range(0, 55));
            dv = ($urandom_range(0, 1) == 1) ? 32'h1 : $urandom;
            eff = (ek >= 0 && ek < TB - 1) ? ek : TB - 1;
            rc = (eff > 1 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, eff - 1)) : -1;
            launch_restart();
            do_run(ek, dv, int'($urandom_range(0, 100)), rc, -1, int'($urandom_range(0, 4)));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Synthesizable run-control block that sits between the board/sim clock-reset source and CPUTop.
- Sequences the CPU reset for a parametrised number of cycles, then counts cycles and retired instructions.
- Detects end-of-test by snooping register-file writes to a designated register, and flags timeout.
- Replaces the fixed reset pulse and fixed run length of the current CPU bench with configurable, observable hardware usable in sim and on FPGA.

Parameters:
- RESET_CYCLES, 4: cycles cpu_nrst is held low after entering RESET; legal range 1..255.
- TIMEOUT_CYCLES, 200000: RUN cycles before timeout is declared; must be ≥1.
- CNT_W, 32: width of cycle_count and retire_count.
- END_REG, 17: register index whose write ends the test (x17/a7); must be non-zero.
- PASS_VALUE, 32'h0000_0001: END_REG write data meaning pass; any other data means fail.

Ports:
- sysclk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: reset; synchronous and active-high.
- restart, input, 1: one-cycle pulse; honoured only in DONE.
- rf_we, input, 1: CPU register-file write enable.
- rf_waddr, input, 5: CPU register-file write address.
- rf_wdata, input, 32: CPU register-file write data.
- retire, input, 1: one pulse per retired instruction.
- cpu_nrst, output, 1: active-low reset driven to CPUTop.
- running, output, 1: high in RUN.
- done, output, 1: high in DONE.
- pass, output, 1: valid when done=1.
- fail, output, 1: valid when done=1.
- timeout, output, 1: valid when done=1.
- cycle_count, output, CNT_W: RUN cycles elapsed.
- retire_count, output, CNT_W: retire pulses counted in RUN.
- end_value, output, 32: data captured from the END_REG write.

Behaviour:
- FSM states are RESET, RUN, DONE.
- rst=1 at a sampled edge:
  - state←RESET, rst_cnt←0.
  - cpu_nrst=0; running, done, pass, fail, timeout=0.
  - cycle_count, retire_count, end_value=0.
  - Takes priority over every other input, including mid-RUN.
- RESET:
  - cpu_nrst=0; rst_cnt increments each cycle.
  - When rst_cnt==RESET_CYCLES-1, next state is RUN.
  - cpu_nrst is therefore low for exactly RESET_CYCLES cycles after rst deasserts.
  - Counters held at 0; snoop inputs ignored.
- RUN:
  - cpu_nrst=1, running=1.
  - cycle_count increments every cycle; it is 0 in the first RUN cycle.
  - retire_count increments on each cycle with retire=1.
  - Both counters saturate at all-ones and never wrap.
- End-of-test in RUN: rf_we=1 and rf_waddr==END_REG.
  - end_value←rf_wdata.
  - pass←(rf_wdata==PASS_VALUE), fail←~pass.
  - Next state is DONE.
- Timeout in RUN: no end-of-test this cycle and cycle_count==TIMEOUT_CYCLES-1.
  - timeout←1, pass=fail=0, next state is DONE.
- Simultaneous end-of-test and timeout condition: end-of-test wins; timeout stays 0.
- Writes to x0, or to any register other than END_REG, are ignored.
- retire counted in the same cycle as the end-of-test write is included in retire_count.
- DONE:
  - cpu_nrst=0, so the CPU is held in reset.
  - running=0, done=1.
  - pass, fail, timeout, counters and end_value are frozen.
  - Exactly one of pass, fail, timeout is 1.
  - Snoop and retire inputs are ignored.
  - restart=1 → state RESET, rst_cnt←0, counters, flags and end_value cleared next cycle.
- restart in RESET or RUN: ignored.
- All outputs are registered; no combinational path from inputs to outputs.
- Latency: an end-of-test write at edge N gives done=1 visible after edge N; cpu_nrst falls after the same edge.

Test Plan:
1. Reset length, RESET_CYCLES=4: rst high 2 cycles then low → cpu_nrst low exactly 4 cycles after rst falls, then 1; running rises with it; cycle_count=0 in the first RUN cycle.
2. Pass path: in RUN, 10 retire pulses, then at cycle_count=25 rf_we=1, rf_waddr=17, rf_wdata=1 → done=1, pass=1, fail=0, timeout=0, end_value=1, retire_count=10, cycle_count=25 frozen, cpu_nrst=0.
3. Fail and ignored writes:
   - Writes to x0 and x16 with data 1 → no effect.
   - Then write x17 with 32'hDEAD_BEEF → fail=1, pass=0, end_value=32'hDEAD_BEEF.
4. Timeout and tie-break, TIMEOUT_CYCLES=50:
   - No end write → done with timeout=1 after cycle_count=49.
   - Rerun with an x17=1 write at cycle_count=49 → pass=1, timeout=0.
5. Restart and mid-run reset:
   - restart in DONE → full RESET sequence, counters cleared, second run passes.
   - restart pulsed in RUN → ignored.
   - rst asserted at cycle_count=30 → all outputs to reset values next edge.
6. Saturation, CNT_W=4, TIMEOUT_CYCLES=40, retire held high → cycle_count and retire_count stick at 15; timeout still fires after 40 RUN cycles, tracked by an internal counter sized for TIMEOUT_CYCLES independent of CNT_W.
